// File: rtl/change_detect_pkg.sv
// Shared constants and helpers for the change_detect input conditioner.
// Edge-mode encodings, the synchronizer depth limit, and the edge-enable decode.
package change_detect_pkg;

  localparam int EDGE_BOTH       = 0;
  localparam int EDGE_RISE       = 1;
  localparam int EDGE_FALL       = 2;
  localparam int MAX_SYNC_STAGES = 4;

  // Mode 3 and any other unlisted encoding fall through to "both edges".
  function automatic logic edge_enabled(input int mode, input logic new_val);
    case (mode)
      EDGE_RISE: edge_enabled = new_val;
      EDGE_FALL: edge_enabled = ~new_val;
      default:   edge_enabled = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/change_detect_sync.sv
// Per-bit flop-chain synchronizer, STAGES deep, cleared asynchronously to 0.
// Only instantiated for STAGES >= 1; the zero-stage case is a plain wire in the parent.
module change_detect_sync
  import change_detect_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_async,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < STAGES; j++) chain[j] <= '0;
    end else begin
      chain[0] <= in_async;
      for (int j = 1; j < STAGES; j++) chain[j] <= chain[j-1];
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/change_detect.sv
// Turns level inputs into one-cycle change strobes: optional synchronizer,
// optional per-bit debounce filter, then edge qualification by EDGE_MODE.
module change_detect
  import change_detect_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_signal,
  output logic [WIDTH-1:0] out_signal
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = in_signal;
    end else begin : g_sync
      change_detect_sync #(
        .WIDTH  (WIDTH),
        .STAGES ((SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : SYNC_STAGES)
      ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_async (in_signal),
        .sync_out (s)
      );
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic             acc;
      logic [CNT_W-1:0] cnt;
      logic             pulse;
      logic             accept;

      // The new level must be seen DEBOUNCE_CYCLES times before the deciding edge;
      // the counter stops at the terminal count, so it cannot wrap.
      assign accept = (DEBOUNCE_CYCLES == 0) || (cnt == CNT_TC);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc   <= 1'b0;
          cnt   <= '0;
          pulse <= 1'b0;
        end else if (s[i] == acc) begin
          cnt   <= '0;
          pulse <= 1'b0;
        end else if (accept) begin
          acc   <= s[i];
          cnt   <= '0;
          pulse <= edge_enabled(EDGE_MODE, s[i]);
        end else begin
          cnt   <= cnt + CNT_W'(1);
          pulse <= 1'b0;
        end
      end

      assign out_signal[i] = pulse;
    end
  endgenerate

endmodule

// File: tb/tb_change_detect.sv
// Directed bench for change_detect across several parameterisations sharing one clock.
// Expected outputs are queued per absolute cycle and checked after each rising edge.
module tb_change_detect;

  logic       clk;
  logic       rst_n;
  logic       in_def, in_rise, in_fall, in_deb;
  logic [3:0] in_w4;
  logic       out_def, out_rise, out_fall, out_deb;
  logic [3:0] out_w4;

  typedef struct {
    string      tag;
    int         dut;
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  change_detect u_def (.clk(clk), .rst_n(rst_n), .in_signal(in_def), .out_signal(out_def));
  change_detect #(.EDGE_MODE(1)) u_rise (.clk(clk), .rst_n(rst_n), .in_signal(in_rise), .out_signal(out_rise));
  change_detect #(.EDGE_MODE(2)) u_fall (.clk(clk), .rst_n(rst_n), .in_signal(in_fall), .out_signal(out_fall));
  change_detect #(.DEBOUNCE_CYCLES(3)) u_deb (.clk(clk), .rst_n(rst_n), .in_signal(in_deb), .out_signal(out_deb));
  change_detect #(.WIDTH(4), .SYNC_STAGES(0)) u_w4 (.clk(clk), .rst_n(rst_n), .in_signal(in_w4), .out_signal(out_w4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] get_out(input int dut);
    case (dut)
      0:       get_out = {3'b000, out_def};
      1:       get_out = {3'b000, out_rise};
      2:       get_out = {3'b000, out_fall};
      3:       get_out = {3'b000, out_deb};
      default: get_out = out_w4;
    endcase
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s (cycle %0d): observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Queue expected values for cycles from..to: val at pulse_at, zero elsewhere.
  task automatic expect_window(input string tag, input int dut, input int from, input int to,
                               input int pulse_at, input logic [3:0] val);
    for (int c = from; c <= to; c++)
      sb.push_back('{tag, dut, c, (c == pulse_at) ? val : 4'b0000});
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc == cyc) begin
        check(sb[k].tag, get_out(sb[k].dut), sb[k].val);
        sb.delete(k);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int c;
    rst_n   = 1'b0;
    in_def  = 1'b1;
    in_rise = 1'b1;
    in_fall = 1'b0;
    in_deb  = 1'b0;
    in_w4   = 4'b0000;

    // Held in reset with inputs high: everything stays quiet.
    for (int d = 0; d < 5; d++) expect_window("reset_hold", d, 1, 3, -1, 4'b0000);
    steps(3);

    // Release; u_rise has its input high through release and must pulse once.
    c = cyc;
    in_def = 1'b0;
    rst_n  = 1'b1;
    expect_window("release_rise_pulse", 1, c + 1, c + 5, c + 3, 4'b0001);
    expect_window("release_def_quiet", 0, c + 1, c + 5, -1, 4'b0000);
    steps(5);

    // Default: rising change before edge k pulses after edge k+2.
    c = cyc;
    in_def = 1'b1;
    expect_window("def_rise_latency", 0, c + 1, c + 5, c + 3, 4'b0001);
    steps(5);

    // Falling change pulses in both-edge mode, not in rise-only mode.
    c = cyc;
    in_def  = 1'b0;
    in_rise = 1'b0;
    expect_window("def_fall_pulse", 0, c + 1, c + 5, c + 3, 4'b0001);
    expect_window("rise_mode_no_fall", 1, c + 1, c + 5, -1, 4'b0000);
    steps(5);

    // Fall-only mode ignores a rise, pulses on the following fall.
    c = cyc;
    in_fall = 1'b1;
    expect_window("fall_mode_no_rise", 2, c + 1, c + 5, -1, 4'b0000);
    steps(5);
    c = cyc;
    in_fall = 1'b0;
    expect_window("fall_mode_fall", 2, c + 1, c + 5, c + 3, 4'b0001);
    steps(5);

    // Toggle every cycle for four cycles: four back-to-back pulses.
    c = cyc;
    for (int k = 1; k <= 8; k++)
      sb.push_back('{"toggle_train", 0, c + k, (k >= 3 && k <= 6) ? 4'b0001 : 4'b0000});
    for (int k = 0; k < 4; k++) begin
      in_def = ~in_def;
      step();
    end
    steps(4);

    // Debounce 3: a two-cycle glitch is filtered.
    c = cyc;
    expect_window("deb_glitch", 3, c + 1, c + 10, -1, 4'b0000);
    in_deb = 1'b1;
    steps(2);
    in_deb = 1'b0;
    steps(8);

    // Debounce 3: a held change pulses three cycles later than undebounced.
    c = cyc;
    in_deb = 1'b1;
    expect_window("deb_hold_rise", 3, c + 1, c + 8, c + 6, 4'b0001);
    steps(8);
    c = cyc;
    in_deb = 1'b0;
    expect_window("deb_hold_fall", 3, c + 1, c + 8, c + 6, 4'b0001);
    steps(8);

    // Four bits, no synchronizer: simultaneous changes pulse together at the next edge.
    c = cyc;
    in_w4 = 4'b1010;
    expect_window("w4_multi_rise", 4, c + 1, c + 3, c + 1, 4'b1010);
    steps(3);
    c = cyc;
    in_w4 = 4'b1000;
    expect_window("w4_single_fall", 4, c + 1, c + 3, c + 1, 4'b0010);
    steps(3);

    // Reset during a pulse and mid-debounce: output drops at once, nothing stale afterwards.
    c = cyc;
    in_def = 1'b1;
    in_deb = 1'b1;
    expect_window("pre_reset_pulse", 0, c + 1, c + 3, c + 3, 4'b0001);
    steps(3);
    #2;
    rst_n  = 1'b0;
    in_def = 1'b0;
    in_deb = 1'b0;
    in_w4  = 4'b0000;
    #1;
    check("async_reset_drop", {3'b000, out_def}, 4'b0000);
    c = cyc;
    expect_window("in_reset_def", 0, c + 1, c + 2, -1, 4'b0000);
    expect_window("in_reset_deb", 3, c + 1, c + 2, -1, 4'b0000);
    steps(2);
    rst_n = 1'b1;
    c = cyc;
    expect_window("post_reset_def", 0, c + 1, c + 10, -1, 4'b0000);
    expect_window("post_reset_deb", 3, c + 1, c + 10, -1, 4'b0000);
    steps(10);

    check("scoreboard_drained", 4'(sb.size()), 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
